// File: rtl/rptr_empty_sync.sv
// Read-side pointer, empty/almost-empty and fill-level logic for a dual-clock FIFO.
// Optional sticky underflow flag: define RPTR_UFLOW_EN.
module rptr_empty_sync #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   rae_thresh,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  logic [ADDRSIZE:0] sync_reg [SYNC_STAGES];
  logic [ADDRSIZE:0] rq_wptr;
  logic [ADDRSIZE:0] wqbin;
  logic [ADDRSIZE:0] rbin_reg;
  logic [ADDRSIZE:0] rptr_reg;
  logic [ADDRSIZE:0] rlevel_reg;
  logic              rempty_reg;
  logic              ralmost_empty_reg;
  logic              rd_en;
  logic [ADDRSIZE:0] rbin_next;
  logic [ADDRSIZE:0] rgray_next;
  logic [ADDRSIZE:0] level_next;

  // Write-pointer synchroniser: plain flop chain, nothing in front of stage 0.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge rclk or posedge rrst) begin
        if (rrst)
          sync_reg[gi] <= '0;
        else if (gi == 0)
          sync_reg[gi] <= wptr;
        else
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
      end
    end
  endgenerate

  assign rq_wptr = sync_reg[SYNC_STAGES-1];

  generate
    for (genvar gi = 0; gi <= ADDRSIZE; gi++) begin : g_g2b
      assign wqbin[gi] = ^rq_wptr[ADDRSIZE:gi];
    end
  endgenerate

  assign rd_en      = rinc & ~rempty_reg;
  assign rbin_next  = rbin_reg + {{ADDRSIZE{1'b0}}, rd_en};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  // Extra MSB on both pointers makes this difference exact up to a full FIFO.
  assign level_next = wqbin - rbin_next;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_reg          <= '0;
      rptr_reg          <= '0;
      rlevel_reg        <= '0;
      rempty_reg        <= 1'b1;
      ralmost_empty_reg <= 1'b1;
    end else begin
      rbin_reg          <= rbin_next;
      rptr_reg          <= rgray_next;
      rlevel_reg        <= level_next;
      rempty_reg        <= (rgray_next == rq_wptr);
      ralmost_empty_reg <= (level_next <= rae_thresh);
    end
  end

`ifdef RPTR_UFLOW_EN
  logic runderflow_reg;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst)
      runderflow_reg <= 1'b0;
    else if (rinc && rempty_reg)
      runderflow_reg <= 1'b1;
  end

  assign runderflow = runderflow_reg;
`else
  assign runderflow = 1'b0;
`endif

  assign raddr         = rbin_reg[ADDRSIZE-1:0];
  assign rptr          = rptr_reg;
  assign rempty        = rempty_reg;
  assign ralmost_empty = ralmost_empty_reg;
  assign rlevel        = rlevel_reg;

  a_empty_level : assert property (@(posedge rclk) disable iff (rrst)
    rempty_reg == (rlevel_reg == '0));

endmodule

// File: tb/tb_rptr_empty_sync.sv
// Directed, table-driven bench for rptr_empty_sync (ADDRSIZE=4, SYNC_STAGES=2).
module tb_rptr_empty_sync;

  logic       rclk = 1'b0;
  logic       rrst = 1'b1;
  logic       rinc = 1'b0;
  logic [4:0] wptr = 5'h07;
  logic [4:0] rae_thresh = 5'd3;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rlevel;
  logic       runderflow;

  int checks = 0;
  int errors = 0;

  rptr_empty_sync #(.ADDRSIZE(4), .SYNC_STAGES(2)) dut (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .wptr(wptr), .rae_thresh(rae_thresh),
    .raddr(raddr), .rptr(rptr), .rempty(rempty), .ralmost_empty(ralmost_empty),
    .rlevel(rlevel), .runderflow(runderflow)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic       rinc;
    logic [4:0] wptr;
    logic [4:0] thr;
    logic       e_empty;
    logic [4:0] e_level;
    logic       e_ae;
    logic [3:0] e_raddr;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  function automatic logic [4:0] g(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic do_reset();
    rrst = 1'b1;
    rinc = 1'b0;
    wptr = '0;
    step();
    rrst = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rempty"}, int'(rempty), 1);
    chk({tag, "_rlevel"}, int'(rlevel), 0);
    chk({tag, "_ralmost"}, int'(ralmost_empty), 1);
    chk({tag, "_raddr"}, int'(raddr), 0);
    chk({tag, "_rptr"}, int'(rptr), 0);
    chk({tag, "_runderflow"}, int'(runderflow), 0);
  endtask

  initial begin
    int wcnt, rd, d1, d2, elev;
    bit exp_uf;

    // rinc, wptr(Gray), thr, empty, level, almost, raddr
    tbl[0]  = '{1'b0, 5'd5,  5'd3,  1'b1, 5'd0, 1'b1, 4'd0};   // wptr=G(6) entering sync
    tbl[1]  = '{1'b0, 5'd5,  5'd3,  1'b1, 5'd0, 1'b1, 4'd0};
    tbl[2]  = '{1'b1, 5'd5,  5'd3,  1'b0, 5'd6, 1'b0, 4'd0};   // rinc while empty ignored
    tbl[3]  = '{1'b1, 5'd5,  5'd3,  1'b0, 5'd5, 1'b0, 4'd1};
    tbl[4]  = '{1'b1, 5'd5,  5'd3,  1'b0, 5'd4, 1'b0, 4'd2};
    tbl[5]  = '{1'b1, 5'd5,  5'd3,  1'b0, 5'd3, 1'b1, 4'd3};
    tbl[6]  = '{1'b1, 5'd5,  5'd3,  1'b0, 5'd2, 1'b1, 4'd4};
    tbl[7]  = '{1'b1, 5'd5,  5'd3,  1'b0, 5'd1, 1'b1, 4'd5};
    tbl[8]  = '{1'b1, 5'd5,  5'd3,  1'b1, 5'd0, 1'b1, 4'd6};
    tbl[9]  = '{1'b1, 5'd5,  5'd3,  1'b1, 5'd0, 1'b1, 4'd6};
    tbl[10] = '{1'b0, 5'd12, 5'd3,  1'b1, 5'd0, 1'b1, 4'd6};   // G(8)
    tbl[11] = '{1'b0, 5'd12, 5'd3,  1'b1, 5'd0, 1'b1, 4'd6};
    tbl[12] = '{1'b0, 5'd12, 5'd3,  1'b0, 5'd2, 1'b1, 4'd6};
    tbl[13] = '{1'b0, 5'd13, 5'd3,  1'b0, 5'd2, 1'b1, 4'd6};   // G(9)
    tbl[14] = '{1'b1, 5'd13, 5'd3,  1'b0, 5'd1, 1'b1, 4'd7};
    tbl[15] = '{1'b1, 5'd13, 5'd3,  1'b0, 5'd1, 1'b1, 4'd8};   // read + arrival same edge
    tbl[16] = '{1'b1, 5'd13, 5'd3,  1'b1, 5'd0, 1'b1, 4'd9};
    tbl[17] = '{1'b0, 5'd15, 5'd0,  1'b1, 5'd0, 1'b1, 4'd9};   // G(10), thresh 0
    tbl[18] = '{1'b0, 5'd15, 5'd0,  1'b1, 5'd0, 1'b1, 4'd9};
    tbl[19] = '{1'b0, 5'd15, 5'd0,  1'b0, 5'd1, 1'b0, 4'd9};
    tbl[20] = '{1'b1, 5'd15, 5'd0,  1'b1, 5'd0, 1'b1, 4'd10};
    tbl[21] = '{1'b0, 5'd15, 5'd16, 1'b1, 5'd0, 1'b1, 4'd10};

    // Reset held with a non-zero wptr
    rrst = 1'b1;
    wptr = 5'h07;
    #12;
    chk_reset_values("reset");
    @(posedge rclk);
    #1;
    rrst = 1'b0;

    foreach (tbl[i]) begin
      rinc = tbl[i].rinc;
      wptr = tbl[i].wptr;
      rae_thresh = tbl[i].thr;
      step();
      chk($sformatf("vec%0d_rempty", i), int'(rempty), int'(tbl[i].e_empty));
      chk($sformatf("vec%0d_rlevel", i), int'(rlevel), int'(tbl[i].e_level));
      chk($sformatf("vec%0d_ralmost", i), int'(ralmost_empty), int'(tbl[i].e_ae));
      chk($sformatf("vec%0d_raddr", i), int'(raddr), int'(tbl[i].e_raddr));
    end

    // Full FIFO: 16 entries visible, then drained with rinc held
    rae_thresh = 5'd3;
    do_reset();
    wptr = 5'd24;  // G(16)
    step();
    step();
    chk("full_pre_rempty", int'(rempty), 1);
    step();
    chk("full_rlevel", int'(rlevel), 16);
    chk("full_rempty", int'(rempty), 0);
    chk("full_raddr", int'(raddr), 0);
    rinc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("drain%0d_raddr", i), int'(raddr), i % 16);
      chk($sformatf("drain%0d_rlevel", i), int'(rlevel), 16 - i);
      chk($sformatf("drain%0d_rempty", i), int'(rempty), (i == 16) ? 1 : 0);
      chk($sformatf("drain%0d_ralmost", i), int'(ralmost_empty), (16 - i <= 3) ? 1 : 0);
    end
    chk("drain_rptr", int'(rptr), 24);

    // Read on empty: pointer holds, underflow flag depends on build
`ifdef RPTR_UFLOW_EN
    exp_uf = 1'b1;
`else
    exp_uf = 1'b0;
`endif
    rinc = 1'b1;
    step();
    chk("uflow_raddr", int'(raddr), 0);
    chk("uflow_rptr", int'(rptr), 24);
    chk("uflow_flag", int'(runderflow), int'(exp_uf));
    rinc = 1'b0;
    step();
    chk("uflow_sticky", int'(runderflow), int'(exp_uf));

    // Random streaming across pointer wrap, checked against a count model
    do_reset();
    wcnt = 0; rd = 0; d1 = 0; d2 = 0; elev = 0;
    for (int cyc = 0; cyc < 250; cyc++) begin
      if ($urandom_range(0, 9) < 6 && (wcnt - rd) < 16) wcnt++;
      wptr = g(wcnt);
      rinc = 1'($urandom_range(0, 1));
      if (rinc && elev != 0) rd++;
      step();
      elev = d2 - rd;
      d2 = d1;
      d1 = wcnt;
      chk($sformatf("stream%0d_rlevel", cyc), int'(rlevel), elev);
      chk($sformatf("stream%0d_rempty", cyc), int'(rempty), (elev == 0) ? 1 : 0);
      chk($sformatf("stream%0d_bound", cyc), int'(rlevel <= 5'd16), 1);
    end

    // Make the FIFO non-empty, then reset between clock edges
    rinc = 1'b0;
    wcnt = rd + 10;
    wptr = g(wcnt);
    step(); step(); step();
    chk("mid_rlevel", int'(rlevel), 10);
    #3;
    rrst = 1'b1;
    #1;
    chk_reset_values("async");
    step();
    rrst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
